// File: rtl/cluster_imem_responder.sv
// Four-lane instruction memory for the cluster controller: 1-cycle registered fetch per lane,
// plus a streaming valid/ready load port that writes a program into the word array.

module cluster_imem_lane #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_serve,
    input  logic        i_en,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data,
    output logic        o_oor
);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic        w_hit;
    logic        w_inr;
    logic [31:0] r_data;
    logic        r_oor;

    assign w_hit = i_serve & i_en;
    assign w_inr = (i_pc < DEPTH_W);

    // Nothing is held: a lane not served this cycle reads back as zero next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_oor  <= 1'b0;
        end else begin
            r_data <= (w_hit && w_inr) ? i_rdata : '0;
            r_oor  <= w_hit && !w_inr;
        end
    end

    assign o_data = r_data;
    assign o_oor  = r_oor;
endmodule

module cluster_imem_responder #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [127:0]      PCsIM,
    input  logic [3:0]        InstReadEn,
    output logic [127:0]      instruction_mem,
    output logic [3:0]        imem_oor,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_err,
    output logic [ADDR_W:0]   load_count
);
    localparam int NUM_LANES = 4;
    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_P   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

    state_t      r_state;
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_load_count;
    logic        r_load_ready;
    logic        r_load_busy;
    logic        r_load_err;
    logic [31:0] r_mem [DEPTH];

    logic [NUM_LANES-1:0][31:0] w_pc;
    logic [NUM_LANES-1:0][31:0] w_rdata;
    logic [NUM_LANES-1:0][31:0] w_lane_data;
    logic [NUM_LANES-1:0]       w_lane_oor;
    logic                       w_serve;
    logic                       w_hs;
    logic                       w_wr_inr;

    assign w_pc     = PCsIM;
    assign w_serve  = (r_state == S_IDLE);
    assign w_hs     = (r_state == S_LOAD) && load_valid;
    assign w_wr_inr = (r_wr_ptr < DEPTH_P);

    // Array has no reset so a program survives a controller reset.
    always_ff @(posedge clk) begin
        if (w_hs && w_wr_inr)
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_load_count <= '0;
            r_load_ready <= 1'b0;
            r_load_busy  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state      <= S_LOAD;
                        r_wr_ptr     <= {1'b0, load_base};
                        r_load_count <= '0;
                        r_load_err   <= 1'b0;
                        r_load_ready <= 1'b1;
                        r_load_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        // Past the end the word is dropped and the pointer parks at DEPTH.
                        if (w_wr_inr)
                            r_wr_ptr <= r_wr_ptr + ONE_P;
                        else
                            r_load_err <= 1'b1;
                        r_load_count <= r_load_count + ONE_P;
                        if (load_last) begin
                            r_state      <= S_FLUSH;
                            r_load_ready <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    r_state     <= S_IDLE;
                    r_load_busy <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_load_ready <= 1'b0;
                    r_load_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign w_rdata[i] = r_mem[w_pc[i][ADDR_W-1:0]];

        cluster_imem_lane #(.DEPTH(DEPTH)) u_lane (
            .clk     (clk),
            .rst     (reset),
            .i_serve (w_serve),
            .i_en    (InstReadEn[i]),
            .i_pc    (w_pc[i]),
            .i_rdata (w_rdata[i]),
            .o_data  (w_lane_data[i]),
            .o_oor   (w_lane_oor[i])
        );
    end

    assign instruction_mem = w_lane_data;
    assign imem_oor        = w_lane_oor;
    assign load_ready      = r_load_ready;
    assign load_busy       = r_load_busy;
    assign load_err        = r_load_err;
    assign load_count      = r_load_count;
endmodule
